// File: rtl/ether_pkg.sv
// Shared types and constants for the MAC receive-side packet reader.
package ether_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;

  typedef logic [2:0] mod_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [63:0] data;
    mod_t        mod;
    logic        sop;
    logic        eop;
    logic        err;
  } rx_word_t;

  // Valid bytes carried by an eop word; mod==0 means a full word.
  function automatic logic [3:0] eop_bytes(input mod_t m);
    return (m == 3'd0) ? 4'(BYTES_PER_WORD) : {1'b0, m};
  endfunction

endpackage

// File: rtl/pkt_rx_fifo.sv
// Synchronous FIFO of rx_word_t; registered output, no fall-through.
module pkt_rx_fifo
  import ether_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_xgmii_rx_n,
  input  logic                     push,
  input  rx_word_t                 wr_word,
  input  logic                     pop,
  output rx_word_t                 rd_word,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  rx_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_word = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge reset_xgmii_rx_n) begin
    if (!reset_xgmii_rx_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_rx_reader.sv
// Reads frames from the MAC pkt_rx_* interface into a FIFO-backed stream
// and keeps good/errored frame and byte statistics.
module pkt_rx_reader
  import ether_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_WORDS  = 1519,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_xgmii_rx_n,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  input  logic [63:0]      pkt_rx_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [2:0]       out_mod,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_err,
  output logic [CNT_W-1:0] stat_frames_ok,
  output logic [CNT_W-1:0] stat_frames_err,
  output logic [47:0]      stat_bytes,
  output logic             ovf_sticky
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WW = $clog2(MAX_WORDS + 2);
  localparam logic [WW-1:0] WSAT = WW'(MAX_WORDS + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WORDS);

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_xgmii_rx_n) begin
    if (!reset_xgmii_rx_n) rst_sync <= '0;
    else                   rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic          ren_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          space_ok;
  logic          last_word;
  logic          fifo_full;
  logic          fifo_empty;
  rx_word_t      wr_word;
  rx_word_t      rd_word;

  // A word requested last cycle is still in flight and must be reserved.
  assign used      = {1'b0, fifo_count} + (CW+1)'(ren_q);
  assign space_ok  = (used <= (CW+1)'(FIFO_DEPTH - 2));
  assign last_word = pkt_rx_val && pkt_rx_eop;

  always_comb begin
    state_nxt  = state;
    pkt_rx_ren = 1'b0;
    case (state)
      IDLE: if (pkt_rx_avail && space_ok) state_nxt = READ;
      READ: begin
        pkt_rx_ren = space_ok && !last_word;
        if (last_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ren_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ren_q <= pkt_rx_ren;
    end
  end

  logic          in_frame;
  logic          proto_q;
  logic [WW-1:0] word_cnt;
  logic          starting;
  logic          headless;
  logic          proto_nxt;
  logic [WW-1:0] cnt_nxt;
  logic          frame_bad;
  logic [47:0]   frame_bytes;

  assign starting  = pkt_rx_sop || !in_frame;
  assign headless  = pkt_rx_val && !pkt_rx_sop && !in_frame;
  // Restart on sop mid-frame and a sop-less start both poison the frame.
  assign proto_nxt = (pkt_rx_sop && in_frame) || headless || (!pkt_rx_sop && proto_q);
  assign cnt_nxt   = starting ? WW'(1) :
                     (word_cnt == WSAT) ? WSAT : word_cnt + 1'b1;
  assign frame_bad = pkt_rx_err || (cnt_nxt > WMAX) || proto_nxt;
  assign frame_bytes = (48'(cnt_nxt) - 48'd1) * 48'(BYTES_PER_WORD)
                     + 48'(eop_bytes(pkt_rx_mod));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame        <= 1'b0;
      proto_q         <= 1'b0;
      word_cnt        <= '0;
      stat_frames_ok  <= '0;
      stat_frames_err <= '0;
      stat_bytes      <= '0;
      ovf_sticky      <= 1'b0;
    end else begin
      if (pkt_rx_val) begin
        in_frame <= !pkt_rx_eop;
        word_cnt <= cnt_nxt;
        proto_q  <= proto_nxt;
        if (pkt_rx_eop) begin
          if (frame_bad) begin
            stat_frames_err <= stat_frames_err + 1'b1;
          end else begin
            stat_frames_ok <= stat_frames_ok + 1'b1;
            stat_bytes     <= stat_bytes + frame_bytes;
          end
        end
      end
      if (pkt_rx_val && fifo_full && !(out_valid && out_ready)) ovf_sticky <= 1'b1;
    end
  end

  always_comb begin
    wr_word      = '0;
    wr_word.data = pkt_rx_data;
    wr_word.mod  = pkt_rx_mod;
    wr_word.sop  = pkt_rx_sop;
    wr_word.eop  = pkt_rx_eop;
    wr_word.err  = headless || (pkt_rx_eop && frame_bad);
  end

  pkt_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk              (clk),
    .reset_xgmii_rx_n (rst_n),
    .push             (pkt_rx_val),
    .wr_word          (wr_word),
    .pop              (out_ready),
    .rd_word          (rd_word),
    .count            (fifo_count),
    .full             (fifo_full),
    .empty            (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rd_word.data;
  assign out_mod   = rd_word.mod;
  assign out_sop   = rd_word.sop;
  assign out_eop   = rd_word.eop;
  assign out_err   = rd_word.err;

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Directed bench for pkt_rx_reader with a behavioural MAC read port.
module tb_pkt_rx_reader;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  mod;
    logic        sop;
    logic        eop;
    logic        err;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        avail0, ren0, val0, sop0, eop0, err0, ov0, ordy0, os0, oe0, oerr0, ovf0;
  logic [2:0]  mod0, om0;
  logic [63:0] data0, od0;
  logic [31:0] ok0, fe0;
  logic [47:0] by0;

  logic        avail1, ren1, val1, sop1, eop1, err1, ov1, ordy1, os1, oe1, oerr1, ovf1;
  logic [2:0]  mod1, om1;
  logic [63:0] data1, od1;
  logic [31:0] ok1, fe1;
  logic [47:0] by1;

  pkt_rx_reader d0 (
    .clk(clk), .reset_xgmii_rx_n(rst_n), .pkt_rx_avail(avail0), .pkt_rx_ren(ren0),
    .pkt_rx_val(val0), .pkt_rx_sop(sop0), .pkt_rx_eop(eop0), .pkt_rx_mod(mod0),
    .pkt_rx_err(err0), .pkt_rx_data(data0), .out_valid(ov0), .out_ready(ordy0),
    .out_data(od0), .out_mod(om0), .out_sop(os0), .out_eop(oe0), .out_err(oerr0),
    .stat_frames_ok(ok0), .stat_frames_err(fe0), .stat_bytes(by0), .ovf_sticky(ovf0)
  );

  pkt_rx_reader #(.MAX_WORDS(4)) d1 (
    .clk(clk), .reset_xgmii_rx_n(rst_n), .pkt_rx_avail(avail1), .pkt_rx_ren(ren1),
    .pkt_rx_val(val1), .pkt_rx_sop(sop1), .pkt_rx_eop(eop1), .pkt_rx_mod(mod1),
    .pkt_rx_err(err1), .pkt_rx_data(data1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .out_mod(om1), .out_sop(os1), .out_eop(oe1), .out_err(oerr1),
    .stat_frames_ok(ok1), .stat_frames_err(fe1), .stat_bytes(by1), .ovf_sticky(ovf1)
  );

  word_t mq0[$], mq1[$], rq0[$], rq1[$];
  int checks = 0;
  int failures = 0;
  int sent0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int which, input int n, input logic [2:0] m,
                            input logic e, input logic [63:0] base);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = base + 64'(i);
      w.mod  = (i == n-1) ? m : 3'd0;
      w.sop  = (i == 0);
      w.eop  = (i == n-1);
      w.err  = (i == n-1) ? e : 1'b0;
      if (which == 0) mq0.push_back(w);
      else            mq1.push_back(w);
    end
  endtask

  task automatic wait_rx(input int which, input int n, input int budget, input string tag);
    int k = 0;
    while (((which == 0) ? rq0.size() : rq1.size()) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'((which == 0) ? rq0.size() : rq1.size()), 64'(n));
  endtask

  task automatic set_ready0(input logic v);
    @(posedge clk); #1;
    ordy0 = v;
  endtask

  // MAC model: ren seen in a cycle returns a word one cycle later.
  initial begin : mac
    word_t w;
    logic f0, f1;
    avail0 = 0; val0 = 0; sop0 = 0; eop0 = 0; err0 = 0; mod0 = '0; data0 = '0;
    avail1 = 0; val1 = 0; sop1 = 0; eop1 = 0; err1 = 0; mod1 = '0; data1 = '0;
    forever begin
      @(negedge clk);
      f0 = ren0;
      f1 = ren1;
      @(posedge clk); #1;
      val0 = 1'b0;
      if (f0 && mq0.size() != 0) begin
        w = mq0.pop_front();
        val0 = 1'b1; data0 = w.data; mod0 = w.mod; sop0 = w.sop; eop0 = w.eop; err0 = w.err;
        sent0++;
      end
      avail0 = (mq0.size() != 0);
      val1 = 1'b0;
      if (f1 && mq1.size() != 0) begin
        w = mq1.pop_front();
        val1 = 1'b1; data1 = w.data; mod1 = w.mod; sop1 = w.sop; eop1 = w.eop; err1 = w.err;
      end
      avail1 = (mq1.size() != 0);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && ov0 && ordy0) rq0.push_back('{od0, om0, os0, oe0, oerr0});
      if (rst_n && ov1 && ordy1) rq1.push_back('{od1, om1, os1, oe1, oerr1});
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e, r, s, tail_n;
    logic [63:0] tail_first;
    rst_n = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ren",   64'(ren0), 64'd0);
    chk("rst_valid", 64'(ov0),  64'd0);
    chk("rst_ok",    64'(ok0),  64'd0);
    chk("rst_err",   64'(fe0),  64'd0);
    chk("rst_bytes", 64'(by0),  64'd0);
    chk("rst_ovf",   64'(ovf0), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 64-byte good frame
    push_frame(0, 8, 3'd0, 1'b0, 64'hA0);
    wait_rx(0, 8, 100, "t1_count");
    for (int i = 0; i < 8; i++) begin
      chk("t1_data",  rq0[i].data, 64'hA0 + 64'(i));
      chk("t1_flags", 64'({rq0[i].sop, rq0[i].eop, rq0[i].err}), 64'({i == 0, i == 7, 1'b0}));
    end
    chk("t1_ok",    64'(ok0), 64'd1);
    chk("t1_err",   64'(fe0), 64'd0);
    chk("t1_bytes", 64'(by0), 64'd64);
    rq0.delete();

    // 61-byte frame with MAC error
    push_frame(0, 8, 3'd5, 1'b1, 64'hB0);
    wait_rx(0, 8, 100, "t2_count");
    chk("t2_eop_flags", 64'({rq0[7].sop, rq0[7].eop, rq0[7].err}), 64'b011);
    chk("t2_eop_mod",   64'(rq0[7].mod), 64'd5);
    chk("t2_sop_flags", 64'({rq0[0].sop, rq0[0].eop, rq0[0].err}), 64'b100);
    chk("t2_ok",    64'(ok0), 64'd1);
    chk("t2_err",   64'(fe0), 64'd1);
    chk("t2_bytes", 64'(by0), 64'd64);
    rq0.delete();

    // 40-word frame against a stalled sink: 7 words fit, ren stops
    set_ready0(1'b0);
    push_frame(0, 40, 3'd0, 1'b0, 64'hC00);
    repeat (80) @(negedge clk);
    chk("t3_stalled_rx", 64'(rq0.size()), 64'd0);
    chk("t3_valid",      64'(ov0),  64'd1);
    chk("t3_ren_off",    64'(ren0), 64'd0);
    chk("t3_ovf_hold",   64'(ovf0), 64'd0);
    set_ready0(1'b1);
    wait_rx(0, 40, 600, "t3_count");
    for (int i = 0; i < 40; i++) chk("t3_data", rq0[i].data, 64'hC00 + 64'(i));
    chk("t3_eop",   64'({rq0[39].eop, rq0[39].err}), 64'b10);
    chk("t3_ovf",   64'(ovf0), 64'd0);
    chk("t3_ok",    64'(ok0), 64'd2);
    chk("t3_bytes", 64'(by0), 64'd384);
    rq0.delete();

    // Back-to-back frames: one idle cycle between eop and next ren
    push_frame(0, 3, 3'd0, 1'b0, 64'hD00);
    push_frame(0, 3, 3'd0, 1'b0, 64'hE00);
    e = -1; r = -1;
    for (int k = 0; k < 100 && r < 0; k++) begin
      @(negedge clk);
      if (val0 && eop0 && e < 0) e = k;
      else if (e >= 0 && ren0 && r < 0) r = k;
    end
    chk("t4_gap", 64'(r - e), 64'd2);
    wait_rx(0, 6, 100, "t4_count");
    chk("t4_f2_sop", rq0[3].data, 64'hE00);
    chk("t4_ok",    64'(ok0), 64'd4);
    chk("t4_bytes", 64'(by0), 64'd432);
    rq0.delete();

    // MAX_WORDS=4 instance: 4 words fits, 6 words oversize
    push_frame(1, 4, 3'd0, 1'b0, 64'hF00);
    push_frame(1, 6, 3'd0, 1'b0, 64'hF10);
    wait_rx(1, 10, 200, "t5_count");
    chk("t5_fit_eop",  64'({rq1[3].eop, rq1[3].err}), 64'b10);
    chk("t5_over_eop", 64'({rq1[9].eop, rq1[9].err}), 64'b11);
    chk("t5_ok",    64'(ok1), 64'd1);
    chk("t5_err",   64'(fe1), 64'd1);
    chk("t5_bytes", 64'(by1), 64'd32);

    // Reset in the middle of an 8-word frame
    s = sent0;
    push_frame(0, 8, 3'd0, 1'b0, 64'h900);
    for (int k = 0; k < 100 && sent0 < s + 3; k++) @(negedge clk);
    chk("t6_reached_w3", 64'(sent0 >= s + 3), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    tail_n = mq0.size();
    tail_first = (tail_n != 0) ? mq0[0].data : 64'd0;
    #1;
    chk("t6_ren",   64'(ren0), 64'd0);
    chk("t6_valid", 64'(ov0),  64'd0);
    chk("t6_ok",    64'(ok0),  64'd0);
    chk("t6_bytes", 64'(by0),  64'd0);
    chk("t6_err0",  64'(fe0),  64'd0);
    repeat (2) @(negedge clk);
    rq0.delete();
    rst_n = 1'b1;
    wait_rx(0, tail_n, 200, "t6_tail_count");
    repeat (3) @(negedge clk);
    if (tail_n > 0) begin
      chk("t6_tail_data",  rq0[0].data, tail_first);
      chk("t6_tail_head",  64'({rq0[0].sop, rq0[0].err}), 64'b01);
      chk("t6_tail_eop",   64'({rq0[tail_n-1].eop, rq0[tail_n-1].err}), 64'b11);
    end
    chk("t6_err",      64'(fe0), 64'd1);
    chk("t6_ok_after", 64'(ok0), 64'd0);
    chk("t6_bytes_after", 64'(by0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
